rom_stream_loader: RTL and testbench

ROM_STREAM_LOADER -- requirements
Module: rom_stream_loader

---
 rtl/rom_stream_loader.sv | 207 ++++++++++++++++++++
 tb/tb_rom_stream_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_loader.sv
// Streams a cfg header plus indexed size/data records into word-wide memory writes.
// Define ROM_LOADER_CHECKSUM_EN to add a per-region 16-bit byte-sum checksum.
module rom_stream_loader #(
    parameter int NUM_REGIONS = 16,
    parameter int WORD_BYTES  = 2,
    parameter int ADDR_W      = 27,
    localparam int RW         = $clog2(NUM_REGIONS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ioctl_wr,
    input  logic [7:0]              ioctl_data,
    output logic                    ioctl_wait,
    output logic [RW-1:0]           region_idx,
    input  logic [ADDR_W-1:0]       region_base,
    input  logic                    region_swap,
    input  logic                    region_en,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_data,
    output logic [WORD_BYTES-1:0]   mem_be,
    output logic                    mem_req,
    input  logic                    mem_ack,
    output logic [15:0]             board_cfg,
    output logic [NUM_REGIONS-1:0]  loaded,
    output logic                    error,
    output logic [15:0]             checksum,
    output logic                    checksum_valid
);

    localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [8:0] NR9 = 9'(NUM_REGIONS);

    typedef enum logic [3:0] {
        CFG0, CFG1, IDX, SZ0, SZ1, SZ2, DATA, SKIP, WAIT
    } state_t;

    state_t                  state;
    logic [23:0]             size_q;
    logic [23:0]             offset;
    logic [ADDR_W-1:0]       base_q;
    logic                    swap_q;
    logic                    bad_idx;
    logic [8*WORD_BYTES-1:0] acc_data;
    logic [WORD_BYTES-1:0]   acc_be;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0]             sum;
`endif

    logic [8*WORD_BYTES-1:0] new_data;
    logic [WORD_BYTES-1:0]   new_be;
    logic [LW-1:0]           kpos;
    logic [LW-1:0]           lane;
    logic                    last_lane;
    logic [23:0]             off_nxt;
    logic [23:0]             off_al;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [23:0]             full_size;
    logic                    idx_bad_c;
    logic [RW-1:0]           idx_inc;

    assign kpos      = LW'(offset % 24'(WORD_BYTES));
    assign lane      = swap_q ? LW'(WORD_BYTES - 1) - kpos : kpos;
    assign last_lane = (kpos == LW'(WORD_BYTES - 1));
    assign off_nxt   = offset + 24'd1;
    assign off_al    = offset & ~24'(WORD_BYTES - 1);
    assign addr_nxt  = base_q + ADDR_W'(off_al);
    assign full_size = {size_q[23:8], ioctl_data};
    assign idx_bad_c = (ioctl_data != 8'hFF) && ({1'b0, ioctl_data} >= NR9);
    assign idx_inc   = (region_idx == RW'(NUM_REGIONS - 1)) ?
                       '0 : region_idx + RW'(1);

    // Merge the incoming byte into its lane of the partially built word
    always_comb begin
        new_data = acc_data;
        new_be   = acc_be;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (LW'(i) == lane) begin
                new_data[i*8 +: 8] = ioctl_data;
                new_be[i]          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CFG0;
            size_q     <= '0;
            offset     <= '0;
            base_q     <= '0;
            swap_q     <= 1'b0;
            bad_idx    <= 1'b0;
            acc_data   <= '0;
            acc_be     <= '0;
            region_idx <= '0;
            ioctl_wait <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_be     <= '0;
            mem_req    <= 1'b0;
            board_cfg  <= '0;
            loaded     <= '0;
            error      <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum            <= '0;
            checksum       <= '0;
            checksum_valid <= 1'b0;
`endif
        end else begin
`ifdef ROM_LOADER_CHECKSUM_EN
            checksum_valid <= 1'b0;
`endif
            unique case (state)
                CFG0: if (ioctl_wr) begin
                    board_cfg[15:8] <= ioctl_data;
                    state           <= CFG1;
                end
                CFG1: if (ioctl_wr) begin
                    board_cfg[7:0] <= ioctl_data;
                    state          <= IDX;
                end
                IDX: if (ioctl_wr) begin
                    if (ioctl_data == 8'hFF)
                        region_idx <= idx_inc;
                    else
                        region_idx <= ioctl_data[RW-1:0];
                    bad_idx <= idx_bad_c;
                    if (idx_bad_c)
                        error <= 1'b1;
                    state <= SZ0;
                end
                SZ0: if (ioctl_wr) begin
                    size_q[23:16] <= ioctl_data;
                    state         <= SZ1;
                end
                SZ1: if (ioctl_wr) begin
                    size_q[15:8] <= ioctl_data;
                    state        <= SZ2;
                end
                SZ2: if (ioctl_wr) begin
                    size_q[7:0] <= ioctl_data;
                    base_q      <= region_base;
                    swap_q      <= region_swap;
                    offset      <= '0;
                    acc_data    <= '0;
                    acc_be      <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                    sum <= '0;
`endif
                    if (full_size == '0)
                        state <= IDX;
                    else if (region_en && !bad_idx)
                        state <= DATA;
                    else
                        state <= SKIP;
                end
                DATA: if (ioctl_wr) begin
                    offset <= off_nxt;
`ifdef ROM_LOADER_CHECKSUM_EN
                    sum <= sum + {8'd0, ioctl_data};
`endif
                    if (last_lane || off_nxt == size_q) begin
                        mem_addr   <= addr_nxt;
                        mem_data   <= new_data;
                        mem_be     <= new_be;
                        mem_req    <= ~mem_req;
                        ioctl_wait <= 1'b1;
                        acc_data   <= '0;
                        acc_be     <= '0;
                        state      <= WAIT;
                    end else begin
                        acc_data <= new_data;
                        acc_be   <= new_be;
                    end
                end
                SKIP: if (ioctl_wr) begin
                    offset <= off_nxt;
                    if (off_nxt == size_q)
                        state <= IDX;
                end
                WAIT: begin
                    if (ioctl_wr)
                        error <= 1'b1;
                    if (mem_ack == mem_req) begin
                        ioctl_wait <= 1'b0;
                        if (offset == size_q) begin
                            loaded[region_idx] <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                            checksum       <= sum;
                            checksum_valid <= 1'b1;
`endif
                            state <= IDX;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                default: state <= CFG0;
            endcase
        end
    end

`ifndef ROM_LOADER_CHECKSUM_EN
    assign checksum       = '0;
    assign checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rom_stream_loader.sv
// Directed bench for rom_stream_loader: WORD_BYTES=2 main instance plus a
// WORD_BYTES=4 instance for partial-word tails.
`timescale 1ns/1ps
module tb_rom_stream_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        wr2 = 1'b0, wr4 = 1'b0;
    logic [7:0]  d2 = '0, d4 = '0;
    logic        wait2, wait4;
    logic [3:0]  idx2, idx4;
    logic [26:0] base2, base4;
    logic        swap2, swap4, en2, en4;
    logic [26:0] addr2, addr4;
    logic [15:0] data2;
    logic [31:0] data4;
    logic [1:0]  be2;
    logic [3:0]  be4;
    logic        req2, req4;
    logic        ack2, ack4;
    logic [15:0] cfg2, cfg4;
    logic [15:0] loaded2, loaded4;
    logic        err2, err4;
    logic [15:0] cs2, cs4;
    logic        csv2, csv4;

    logic [26:0] btab [16];
    logic        stab [16];
    logic        etab [16];

    assign base2 = btab[idx2];
    assign swap2 = stab[idx2];
    assign en2   = etab[idx2];
    assign base4 = btab[idx4];
    assign swap4 = stab[idx4];
    assign en4   = etab[idx4];

    rom_stream_loader #(.NUM_REGIONS(16), .WORD_BYTES(2), .ADDR_W(27)) dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_wr(wr2), .ioctl_data(d2), .ioctl_wait(wait2),
        .region_idx(idx2), .region_base(base2),
        .region_swap(swap2), .region_en(en2),
        .mem_addr(addr2), .mem_data(data2), .mem_be(be2),
        .mem_req(req2), .mem_ack(ack2),
        .board_cfg(cfg2), .loaded(loaded2), .error(err2),
        .checksum(cs2), .checksum_valid(csv2)
    );

    rom_stream_loader #(.NUM_REGIONS(16), .WORD_BYTES(4), .ADDR_W(27)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .ioctl_wr(wr4), .ioctl_data(d4), .ioctl_wait(wait4),
        .region_idx(idx4), .region_base(base4),
        .region_swap(swap4), .region_en(en4),
        .mem_addr(addr4), .mem_data(data4), .mem_be(be4),
        .mem_req(req4), .mem_ack(ack4),
        .board_cfg(cfg4), .loaded(loaded4), .error(err4),
        .checksum(cs4), .checksum_valid(csv4)
    );

    // Parent-side ack: follow the request after dly2 extra cycles
    int dly2 = 0;
    int cnt2;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack2 <= 1'b0;
            cnt2 <= 0;
        end else if (ack2 != req2) begin
            if (cnt2 >= dly2) begin
                ack2 <= req2;
                cnt2 <= 0;
            end else begin
                cnt2 <= cnt2 + 1;
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ack4 <= 1'b0;
        else          ack4 <= req4;
    end

    typedef struct {
        logic [26:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t  q2[$];
    wr_t  q4[$];
    logic preq2 = 1'b0, preq4 = 1'b0;
    int   pulses = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            preq2 <= 1'b0;
            preq4 <= 1'b0;
        end else begin
            if (req2 != preq2) begin
                q2.push_back('{addr2, 32'(data2), 4'(be2)});
                preq2 <= req2;
            end
            if (req4 != preq4) begin
                q4.push_back('{addr4, data4, be4});
                preq4 <= req4;
            end
        end
        if (csv2) pulses <= pulses + 1;
    end

    typedef struct {
        logic [7:0]  b;
        logic        wexp;
        logic [26:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        ichk;
        logic [3:0]  iexp;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    function automatic void ab(input logic [7:0] b);
        vq.push_back('{b, 1'b0, 27'd0, 32'd0, 4'd0, 1'b0, 4'd0});
    endfunction

    function automatic void aw(input logic [7:0] b, input logic [26:0] a,
                               input logic [31:0] d, input logic [3:0] be);
        vq.push_back('{b, 1'b1, a, d, be, 1'b0, 4'd0});
    endfunction

    function automatic void ai(input logic [7:0] b, input logic [3:0] ie);
        vq.push_back('{b, 1'b0, 27'd0, 32'd0, 4'd0, 1'b1, ie});
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] b);
        int t;
        t = 0;
        while (((sel == 4) ? wait4 : wait2) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: ioctl_wait stuck high sel %0d", sel);
        end
        if (sel == 4) begin wr4 = 1'b1; d4 = b; end
        else          begin wr2 = 1'b1; d2 = b; end
        @(negedge clk);
        wr2 = 1'b0;
        wr4 = 1'b0;
    endtask

    task automatic getw(input int sel, input string nm, input logic [26:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        int t;
        wr_t w;
        t = 0;
        while (((sel == 4) ? q4.size() : q2.size()) == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (((sel == 4) ? q4.size() : q2.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no write seen, expected addr %h", nm, a);
        end else begin
            w = (sel == 4) ? q4.pop_front() : q2.pop_front();
            chk({nm, "_addr"}, 32'(w.a), 32'(a));
            chk({nm, "_be"}, 32'(w.be), 32'(be));
            chk({nm, "_data"}, w.d & bmask(be), d & bmask(be));
        end
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 16; i++) begin
            btab[i] = 27'(i * 27'h10000);
            stab[i] = 1'b0;
            etab[i] = 1'b1;
        end
        btab[0]  = 27'h100;
        btab[1]  = 27'h200;
        btab[2]  = 27'h300;
        btab[3]  = 27'h40;
        btab[15] = 27'h1000;
        stab[1]  = 1'b1;
        etab[5]  = 1'b0;

        ab(8'h12); ab(8'h34);
        ai(8'h00, 4'd0); ab(8'h00); ab(8'h00); ab(8'h04);
        ab(8'hAA); aw(8'hBB, 27'h100, 32'hBBAA, 4'b0011);
        ab(8'hCC); aw(8'hDD, 27'h102, 32'hDDCC, 4'b0011);
        ai(8'h01, 4'd1); ab(8'h00); ab(8'h00); ab(8'h04);
        ab(8'hAA); aw(8'hBB, 27'h200, 32'hAABB, 4'b0011);
        ab(8'hCC); aw(8'hDD, 27'h202, 32'hCCDD, 4'b0011);
        ai(8'h02, 4'd2); ab(8'h00); ab(8'h00); ab(8'h03);
        ab(8'h11); aw(8'h22, 27'h300, 32'h2211, 4'b0011);
        aw(8'h33, 27'h302, 32'h0033, 4'b0001);
        ai(8'h05, 4'd5); ab(8'h00); ab(8'h00); ab(8'h03);
        ab(8'h01); ab(8'h02); ab(8'h03);
        ai(8'h0F, 4'd15); ab(8'h00); ab(8'h00); ab(8'h01);
        aw(8'h77, 27'h1000, 32'h0077, 4'b0001);
        ai(8'hFF, 4'd0); ab(8'h00); ab(8'h00); ab(8'h00);
        ai(8'h20, 4'd0); ab(8'h00); ab(8'h00); ab(8'h02);
        ab(8'h55); ab(8'h66);

        repeat (2) @(negedge clk);
        chk("rst_cfg", 32'(cfg2), 32'h0);
        chk("rst_loaded", 32'(loaded2), 32'h0);
        chk("rst_err", 32'(err2), 32'h0);
        chk("rst_wait", 32'(wait2), 32'h0);
        chk("rst_req", 32'(req2), 32'h0);
        chk("rst_be", 32'(be2), 32'h0);
        chk("rst_idx", 32'(idx2), 32'h0);
        chk("rst_cs", 32'(cs2), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            send(2, vq[i].b);
            if (vq[i].ichk)
                chk($sformatf("idx_v%0d", i), 32'(idx2), 32'(vq[i].iexp));
            if (vq[i].wexp)
                getw(2, $sformatf("wr_v%0d", i), vq[i].a, vq[i].d, vq[i].be);
        end
        repeat (4) @(negedge clk);
        chk("board_cfg", 32'(cfg2), 32'h1234);
        chk("loaded_map", 32'(loaded2), 32'h8007);
        chk("bad_idx_err", 32'(err2), 32'h1);
        chk("extra_writes", 32'(q2.size()), 32'h0);

        send(4, 8'h00); send(4, 8'h00);
        send(4, 8'h03); send(4, 8'h00); send(4, 8'h00); send(4, 8'h05);
        send(4, 8'h01); send(4, 8'h02); send(4, 8'h03); send(4, 8'h04);
        getw(4, "w4_full", 27'h40, 32'h04030201, 4'b1111);
        send(4, 8'h05);
        getw(4, "w4_tail", 27'h44, 32'h00000005, 4'b0001);
        repeat (3) @(negedge clk);
        chk("w4_loaded3", 32'(loaded4[3]), 32'h1);

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        q2.delete();
        dly2 = 10;
        @(negedge clk);
        send(2, 8'h00); send(2, 8'h00);
        send(2, 8'h00); send(2, 8'h00); send(2, 8'h00); send(2, 8'h02);
        send(2, 8'hAA); send(2, 8'hBB);
        getw(2, "slow_wr", 27'h100, 32'hBBAA, 4'b0011);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("wait_hold%0d", c), 32'(wait2), 32'h1);
            if (c == 3) begin
                wr2 = 1'b1;
                d2 = 8'h99;
            end else begin
                wr2 = 1'b0;
            end
            @(negedge clk);
        end
        wr2 = 1'b0;
        chk("wait_wr_err", 32'(err2), 32'h1);
        chk("wait_wr_data", 32'(data2), 32'hBBAA);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_wait", 32'(wait2), 32'h0);
        chk("mid_rst_req", 32'(req2), 32'h0);
        chk("mid_rst_addr", 32'(addr2), 32'h0);
        chk("mid_rst_data", 32'(data2), 32'h0);
        chk("mid_rst_be", 32'(be2), 32'h0);
        chk("mid_rst_cfg", 32'(cfg2), 32'h0);
        chk("mid_rst_err", 32'(err2), 32'h0);
        chk("mid_rst_loaded", 32'(loaded2), 32'h0);
        chk("mid_rst_cs", 32'({cs2, csv2}), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        dly2 = 0;
        @(negedge clk);
        send(2, 8'h56); send(2, 8'h78);
        chk("cfg_after_rst", 32'(cfg2), 32'h5678);
        chk("abandoned_word", 32'(q2.size()), 32'h0);

        p0 = pulses;
        send(2, 8'h00); send(2, 8'h00); send(2, 8'h00); send(2, 8'h04);
        send(2, 8'h01); send(2, 8'h02);
        getw(2, "cs_w0", 27'h100, 32'h0201, 4'b0011);
        send(2, 8'h03); send(2, 8'hFF);
        getw(2, "cs_w1", 27'h102, 32'hFF03, 4'b0011);
        repeat (5) @(negedge clk);
        chk("cs_loaded0", 32'(loaded2[0]), 32'h1);
`ifdef ROM_LOADER_CHECKSUM_EN
        chk("checksum", 32'(cs2), 32'h0105);
        chk("cs_pulses", 32'(pulses - p0), 32'h1);
`else
        chk("checksum_off", 32'(cs2), 32'h0);
        chk("cs_pulses_off", 32'(pulses - p0), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
